raizing_cen_bank: RTL

//  Parametrised bank of NCH fractional clock-enable generators for Raizing/Toaplan2 cores.

---
 rtl/raizing_cen_bank.sv | 116 +++++++++++
 1 files changed

// File: rtl/raizing_cen_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | raizing_cen_bank: bank of NCH fractional clock-enable generators with a   |
// | run-time rate table selected by mode, per-channel pause and global sync.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module raizing_cen_bank #(
  parameter  int NCH     = 4,
  parameter  int W       = 16,
  parameter  int MODE_W  = 2,
  parameter  int DEF_NUM = 1,
  parameter  int DEF_DEN = 12,
  localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MODE_W-1:0] mode,
  input  logic              sync,
  input  logic [NCH-1:0]    pause,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [MODE_W-1:0] cfg_mode,
  input  logic [W-1:0]      cfg_num,
  input  logic [W-1:0]      cfg_den,
  output logic              cfg_err,
  output logic [NCH-1:0]    cen,
  output logic [NCH-1:0]    cenb
);

  localparam int            C_NMODE = 2**MODE_W;
  localparam logic [CH_W:0] C_NCH   = (CH_W+1)'(NCH);

  logic [MODE_W-1:0] r_mode_q;
  logic              r_cfg_err;
  logic              w_clr;
  logic              w_legal;
  logic              w_wr;

  assign w_clr   = sync | (mode != r_mode_q);
  assign w_legal = (cfg_den != '0) && ({cfg_num, 1'b0} <= {1'b0, cfg_den}) &&
                   ({1'b0, cfg_ch} < C_NCH);
  assign w_wr    = cfg_we & w_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_q  <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_mode_q  <= mode;
      r_cfg_err <= cfg_we & ~w_legal;
    end
  end

  assign cfg_err = r_cfg_err;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [W-1:0] r_num [C_NMODE];
    logic [W-1:0] r_den [C_NMODE];
    logic [W:0]   r_acc;
    logic         r_phase;
    logic         r_cen;
    logic         r_cenb;
    logic [W:0]   w_sum;
    logic [W:0]   w_den;
    logic [W:0]   w_nxt;
    logic         w_sel;
    logic         w_hit;
    logic         w_ovf;

    // Accumulator counts half-periods: each overflow toggles the phase.
    assign w_sel = w_wr && (cfg_ch == CH_W'(c));
    assign w_hit = w_sel && (cfg_mode == r_mode_q);
    assign w_den = {1'b0, r_den[r_mode_q]};
    assign w_sum = r_acc + {r_num[r_mode_q], 1'b0};
    assign w_ovf = (w_sum >= w_den);
    assign w_nxt = pause[c] ? r_acc : (w_ovf ? (w_sum - w_den) : w_sum);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int m = 0; m < C_NMODE; m++) begin
          r_num[m] <= W'(DEF_NUM);
          r_den[m] <= W'(DEF_DEN);
        end
        r_acc   <= '0;
        r_phase <= 1'b0;
        r_cen   <= 1'b0;
        r_cenb  <= 1'b0;
      end else begin
        r_cen  <= 1'b0;
        r_cenb <= 1'b0;
        if (w_sel) begin
          r_num[cfg_mode] <= cfg_num;
          r_den[cfg_mode] <= cfg_den;
        end
        if (w_clr) begin
          r_acc   <= '0;
          r_phase <= 1'b0;
        end else begin
          if (!pause[c] && w_ovf) begin
            r_phase <= ~r_phase;
            r_cen   <= ~r_phase;
            r_cenb  <= r_phase;
          end
          // A shrinking denominator on the live entry must not strand acc above it.
          if (w_hit && (w_nxt >= {1'b0, cfg_den})) r_acc <= '0;
          else                                     r_acc <= w_nxt;
        end
      end
    end

    assign cen[c]  = r_cen;
    assign cenb[c] = r_cenb;
  end

endmodule
`default_nettype wire
